// File: rtl/pulse_to_level_hs.sv
// -----------------------------------------------------------------------------
// pulse_to_level_hs
//
// Turns single-cycle event pulses into a held request level for a host that
// answers with a four-phase req/ack handshake. Each event yields exactly one
// level_out high/low transaction. Events that arrive while a transaction is
// running are counted and replayed one after another.
//
// Parameters
//   MIN_HOLD  minimum number of cycles level_out stays high (>= 1)
//   CNT_W     width of the pending-event counter (saturating)
//   SYNC_ACK  1: ack_in goes through a 2-flop synchronizer, 0: used directly
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   pulse_in   event strobe, one event per high cycle
//   ack_in     host acknowledge level
//   clr_ovf    synchronous clear of the overflow flag
//   level_out  request level to the host (registered)
//   busy       high whenever a transaction or replay is in progress (registered)
//   pending    queued events not yet issued (registered)
//   overflow   sticky: an event was dropped at counter saturation (registered)
// -----------------------------------------------------------------------------
module pulse_to_level_hs #(
  parameter int MIN_HOLD = 1,
  parameter int CNT_W    = 4,
  parameter bit SYNC_ACK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             clr_ovf,
  output logic             level_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int                HOLD_W   = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0]  PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Acknowledge conditioning
  // ---------------------------------------------------------------------------
  logic ack_s;

  if (SYNC_ACK) begin : g_sync
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    assign sync_d = {sync_q[0], ack_in};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= sync_d;
    end

    assign ack_s = sync_q[1];
  end else begin : g_direct
    assign ack_s = ack_in;
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [HOLD_W-1:0]   hold_q,     hold_d;
  logic [CNT_W-1:0]    pending_q,  pending_d;
  logic                overflow_q, overflow_d;
  logic                level_q;
  logic                busy_q;

  logic replay;   // WAIT_LOW restarts from the pending queue
  logic consume;  // WAIT_LOW restarts directly on this cycle's pulse
  logic count;    // pulse that must be queued
  logic lost;     // pulse dropped because the queue is full

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    replay     = 1'b0;
    consume    = 1'b0;
    lost       = 1'b0;

    case (state_q)
      IDLE: begin
        // ack_s is deliberately ignored here; a stale high ack cannot
        // start or shorten anything until a fresh pulse arrives.
        if (pulse_in) begin
          state_d = REQ;
          hold_d  = HOLD_W'(1);
        end
      end

      REQ: begin
        if (hold_q < HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
        if (ack_s && (hold_q >= HOLD_MAX)) state_d = WAIT_LOW;
      end

      WAIT_LOW: begin
        if (!ack_s) begin
          if (pending_q != '0) begin
            state_d = REQ;
            hold_d  = HOLD_W'(1);
            replay  = 1'b1;
          end else if (pulse_in) begin
            state_d = REQ;
            hold_d  = HOLD_W'(1);
            consume = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // An IDLE pulse is consumed by the IDLE->REQ move, so only pulses seen
    // while busy (and not taken by a direct restart) are queued.
    count = pulse_in && (state_q != IDLE) && !consume;

    if (count && !replay) begin
      if (pending_q == PEND_MAX) lost = 1'b1;
      else                       pending_d = pending_q + CNT_W'(1);
    end else if (!count && replay) begin
      pending_d = pending_q - CNT_W'(1);
    end

    // Set has priority over clear so a drop is never hidden.
    if (clr_ovf) overflow_d = 1'b0;
    if (lost)    overflow_d = 1'b1;
  end

  // Outputs are registered from the next state, so level_out/busy line up
  // with state_q without extra delay.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      level_q    <= (state_d == REQ);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_to_level_hs.sv
// -----------------------------------------------------------------------------
// tb_pulse_to_level_hs
//
// Two instances: dut_a (MIN_HOLD=1, CNT_W=4, synchronized ack) and
// dut_b (MIN_HOLD=5, CNT_W=2, direct ack). Every transaction the stimulus
// expects is pushed to a per-instance queue with its expected high length;
// a negedge monitor pops and compares when level_out falls.
// -----------------------------------------------------------------------------
module tb_pulse_to_level_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] pulse;
  logic [1:0] ack;
  logic [1:0] clr;

  logic       lvl_a, busy_a, ovf_a;
  logic [3:0] pend_a;
  logic       lvl_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  int checks   = 0;
  int failures = 0;

  int unsigned exp_a[$];
  int unsigned exp_b[$];

  pulse_to_level_hs #(.MIN_HOLD(1), .CNT_W(4), .SYNC_ACK(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse[0]),
    .ack_in    (ack[0]),
    .clr_ovf   (clr[0]),
    .level_out (lvl_a),
    .busy      (busy_a),
    .pending   (pend_a),
    .overflow  (ovf_a)
  );

  pulse_to_level_hs #(.MIN_HOLD(5), .CNT_W(2), .SYNC_ACK(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse[1]),
    .ack_in    (ack[1]),
    .clr_ovf   (clr[1]),
    .level_out (lvl_b),
    .busy      (busy_b),
    .pending   (pend_b),
    .overflow  (ovf_b)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned get_lvl(input int d);
    return (d == 0) ? int'(lvl_a) : int'(lvl_b);
  endfunction

  function automatic int unsigned get_busy(input int d);
    return (d == 0) ? int'(busy_a) : int'(busy_b);
  endfunction

  function automatic int unsigned get_pend(input int d);
    return (d == 0) ? int'(pend_a) : int'(pend_b);
  endfunction

  function automatic int unsigned get_ovf(input int d);
    return (d == 0) ? int'(ovf_a) : int'(ovf_b);
  endfunction

  task automatic push_exp(input int d, input int unsigned len);
    if (d == 0) exp_a.push_back(len);
    else        exp_b.push_back(len);
  endtask

  // Advance n rising edges and settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input int d, input int unsigned v, input int budget,
                            input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while ((get_lvl(d) != v) && (n < budget));
    check(tag, get_lvl(d), v);
  endtask

  task automatic wait_idle(input int d, input int budget, input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while ((get_busy(d) != 0) && (n < budget));
    check(tag, get_busy(d), 0);
  endtask

  // Host responder for a running transaction with ack already high:
  // completes it, then handles `replays` queued transactions, checking the
  // pending count as each replay starts.
  task automatic drain(input int d, input int replays);
    for (int r = replays; r >= 1; r--) begin
      wait_level(d, 0, 20, $sformatf("d%0d_drain_fall_%0d", d, r));
      ack[d] = 1'b0;
      wait_level(d, 1, 20, $sformatf("d%0d_drain_rise_%0d", d, r));
      check($sformatf("d%0d_replay_pending_%0d", d, r), get_pend(d), r - 1);
      ack[d] = 1'b1;
    end
    wait_level(d, 0, 20, $sformatf("d%0d_drain_last_fall", d));
    ack[d] = 1'b0;
    wait_idle(d, 20, $sformatf("d%0d_drain_idle", d));
    check($sformatf("d%0d_drain_pending", d), get_pend(d), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction monitors: measure each level_out high period and compare it
  // with the oldest expected entry. A transaction cut by reset is discarded.
  // ---------------------------------------------------------------------------
  int unsigned len_a = 0, len_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      len_a = 0;
    end else if (lvl_a) begin
      len_a++;
    end else if (len_a != 0) begin
      if (exp_a.size() == 0) check("a_unexpected_txn", len_a, 0);
      else                   check("a_hold_len", len_a, exp_a.pop_front());
      len_a = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      len_b = 0;
    end else if (lvl_b) begin
      len_b++;
    end else if (len_b != 0) begin
      if (exp_b.size() == 0) check("b_unexpected_txn", len_b, 0);
      else                   check("b_hold_len", len_b, exp_b.pop_front());
      len_b = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b0;
    pulse = 2'b11;
    ack   = 2'b11;
    clr   = 2'b00;

    // Reset holds everything low even with pulse and ack asserted.
    step(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_level", d),    get_lvl(d),  0);
      check($sformatf("d%0d_rst_busy", d),     get_busy(d), 0);
      check($sformatf("d%0d_rst_pending", d),  get_pend(d), 0);
      check($sformatf("d%0d_rst_overflow", d), get_ovf(d),  0);
    end
    pulse = 2'b00;
    ack   = 2'b00;
    rst   = 1'b1;
    step(5);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_post_rst_level", d), get_lvl(d),  0);
      check($sformatf("d%0d_post_rst_busy", d),  get_busy(d), 0);
    end

    // Single transaction, dut_a (synchronized ack).
    pulse[0] = 1'b1;                 // c0
    push_exp(0, 5);
    step(1);                         // c1
    pulse[0] = 1'b0;
    check("single_level_c1", lvl_a, 1);
    check("single_busy_c1", busy_a, 1);
    step(2);                         // c3
    ack[0] = 1'b1;
    step(2);                         // c5
    check("single_level_c5", lvl_a, 1);
    step(1);                         // c6
    check("single_level_c6", lvl_a, 0);
    check("single_busy_c6", busy_a, 1);
    step(2);                         // c8
    ack[0] = 1'b0;
    step(2);                         // c10
    check("single_busy_c10", busy_a, 1);
    step(1);                         // c11
    check("single_busy_c11", busy_a, 0);

    // Direct restart: pulse on the cycle WAIT_LOW first sees ack_s low.
    step(2);
    pulse[0] = 1'b1;                 // c0
    push_exp(0, 3);
    push_exp(0, 3);
    step(1);                         // c1
    pulse[0] = 1'b0;
    ack[0]   = 1'b1;
    step(3);                         // c4
    check("direct_level_c4", lvl_a, 0);
    ack[0] = 1'b0;
    step(2);                         // c6
    check("direct_gap_level", lvl_a, 0);
    check("direct_gap_busy", busy_a, 1);
    pulse[0] = 1'b1;
    step(1);                         // c7
    pulse[0] = 1'b0;
    check("direct_level_c7", lvl_a, 1);
    check("direct_pending_c7", pend_a, 0);
    ack[0] = 1'b1;
    step(3);                         // c10
    check("direct_level_c10", lvl_a, 0);
    ack[0] = 1'b0;
    wait_idle(0, 10, "direct_idle");

    // Queueing: one pulse starts, three more during REQ are queued.
    step(2);
    pulse[0] = 1'b1;                 // c0..c3
    push_exp(0, 6);
    push_exp(0, 3);
    push_exp(0, 3);
    push_exp(0, 3);
    step(4);                         // c4
    pulse[0] = 1'b0;
    check("queue_pending_3", pend_a, 3);
    check("queue_overflow", ovf_a, 0);
    ack[0] = 1'b1;
    drain(0, 3);

    // Reset in REQ with two queued events: async clear, no replay.
    step(2);
    pulse[0] = 1'b1;                 // c0..c2
    step(3);                         // c3
    check("rst_mid_pending_2", pend_a, 2);
    check("rst_mid_level_1", lvl_a, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_async_level", lvl_a, 0);
    check("rst_mid_async_pending", pend_a, 0);
    check("rst_mid_async_busy", busy_a, 0);
    pulse[0] = 1'b0;
    step(2);
    rst = 1'b1;
    step(6);
    check("rst_mid_no_replay_level", lvl_a, 0);
    check("rst_mid_no_replay_busy", busy_a, 0);
    check("rst_mid_no_replay_pending", pend_a, 0);

    // Min-hold on dut_b: ack already high before the pulse.
    ack[1] = 1'b1;
    step(2);
    pulse[1] = 1'b1;                 // c0
    push_exp(1, 5);
    step(1);                         // c1
    pulse[1] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("minhold_level_c%0d", i), lvl_b, 1);
      step(1);
    end                              // c6
    check("minhold_level_c6", lvl_b, 0);
    check("minhold_busy_c6", busy_b, 1);
    step(2);                         // c8
    check("minhold_busy_c8", busy_b, 1);
    ack[1] = 1'b0;
    step(1);                         // c9
    check("minhold_busy_c9", busy_b, 0);

    // Saturation on dut_b (CNT_W=2).
    step(2);
    pulse[1] = 1'b1;                 // c0..c6
    push_exp(1, 8);
    push_exp(1, 5);
    push_exp(1, 5);
    push_exp(1, 5);
    step(6);                         // c6
    check("sat_pending", pend_b, 3);
    check("sat_overflow", ovf_b, 1);
    clr[1] = 1'b1;                   // clear together with a 6th pulse
    step(1);                         // c7
    pulse[1] = 1'b0;
    check("sat_set_beats_clr", ovf_b, 1);
    step(1);                         // c8 (clear alone)
    clr[1] = 1'b0;
    check("sat_clr_alone", ovf_b, 0);
    check("sat_pending_held", pend_b, 3);
    ack[1] = 1'b1;
    drain(1, 3);

    step(4);
    check("a_scoreboard_empty", exp_a.size(), 0);
    check("b_scoreboard_empty", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
